pipe_wall_chain: RTL and testbench
==================================

Name: pipe_wall_chain

Overview:
Parametrised pipeline-register chain of DEPTH stages, each WIDTH bits wide, with a valid bit per stage. It is the generic successor to the fixed IF/ID/EX/MEM/WB register walls. Adds per-stage stall with upstream back-pressure, per-stage flush and automatic bubble insertion, and exposes every stage's contents for forwarding and hazard logic. Sits between pipeline stages of the core; one instance per datapath field group.

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 4, number of register stages; legal range 2..8
TAG_W, 10, trace tag width; used only when PIPE_TRACE_EN is defined

Ports:
clock  in  1  single clock; all state updates on posedge
reset_n  in  1  asynchronous active-low reset
in_valid_i  in  1  stage-0 input valid
in_data_i  in  WIDTH  stage-0 input payload
in_ready_o  out  1  stage 0 will accept input this cycle
stall_i  in  DEPTH  bit k: hold stage k this cycle
flush_i  in  DEPTH  bit k: clear stage k this cycle
stage_valid_o  out  DEPTH  valid bit of every stage
stage_data_o  out  DEPTH*WIDTH  stage k payload at bits [k*WIDTH +: WIDTH]
out_valid_o  out  1  equals stage_valid_o[DEPTH-1]
out_data_o  out  WIDTH  equals stage k=DEPTH-1 payload
occupancy_o  out  $clog2(DEPTH+1)  count of valid stages (combinational popcount)

Behaviour:
- Reset: while reset_n=0, asynchronously clear all stage valid and data bits to 0. All outputs read 0, except in_ready_o, which reads 1.
- Effective hold: h[DEPTH-1]=stall_i[DEPTH-1]; h[k]=stall_i[k] | h[k+1]. A stall therefore freezes its own stage and every upstream stage.
- in_ready_o = ~h[0] (combinational).
- Per-stage update at posedge, in priority order:
  1. flush_i[k]: valid=0, data=0.
  2. h[k]: hold current valid and data.
  3. k=0: valid=in_valid_i, data=in_data_i; data is captured even when in_valid_i=0.
  4. k>0 and h[k-1]=1: bubble, valid=0, data=0 (the all-zero payload is the NOP encoding).
  5. Otherwise: copy stage k-1.
- Flush has priority over stall. Flushing stage k does not affect any other stage. When stage k is flushed and stage k+1 advances, stage k+1 receives stage k's pre-flush contents.
- Latency: DEPTH cycles from input to out_*, with no stalls.
- The last stage is never back-pressured externally; out_* is consumed every cycle unless stall_i[DEPTH-1] is set.
- Simultaneous stall_i and flush_i on the same stage: flush wins; upstream stages still hold.
- Reset asserted mid-operation discards all contents immediately. Stage state updates resume on the first posedge after deassertion; reset_n is synchronised externally.
- All outputs are register-driven, except in_ready_o and occupancy_o, which are combinational.

Optional Feature:
PIPE_TRACE_EN
- Defined: adds input in_tag_i [TAG_W-1:0] and output stage_tag_o [DEPTH*TAG_W-1:0].
  - Tags follow exactly the same hold, copy and bubble rules as the payload.
  - Flush, bubble and reset load tag value 0.
  - Used to carry the fetch PC for debug.
- Undefined: these ports and their registers do not exist. Behaviour of all other ports is identical.

Decomposition:
- Package pipe_wall_pkg holds:
  - PIPE_MAX_DEPTH = 8
  - PIPE_NOP = 0
  - the stage_ctl_e enum {CTL_LOAD, CTL_HOLD, CTL_BUBBLE, CTL_FLUSH}
  - function clog2_depth
- One sub-module, pipe_wall_stage: a single valid+data(+tag) register. Its control input is the stage_ctl_e decision. The chain generates DEPTH instances, with the hold/priority logic kept in the parent.

Test Plan (WIDTH=32, DEPTH=4):
1. Streaming: feed 0x11,0x22,0x33,0x44,0x55 with in_valid_i=1 and no stalls -> out_data_o=0x11 four cycles after the first input, then one word per cycle; occupancy_o reaches 4.
2. Mid-stall: stall_i=4'b0100 for 2 cycles while streaming -> stages 0..2 hold; stage 3 gets a bubble (out_valid_o=0, out_data_o=0) for 2 cycles; in_ready_o=0 during the stall; no data lost or duplicated.
3. Flush priority: stall_i=4'b0010 and flush_i=4'b0010 in the same cycle while stage 1 holds 0x22 -> stage 1 becomes valid=0, data=0; stage 0 still holds.
4. Branch flush: flush_i=4'b0011 with stages holding 0xA0..0xA3 -> stages 0,1 cleared; stages 2,3 advance normally; occupancy_o drops by 2.
5. Async reset: assert reset_n=0 between clock edges with a full pipe -> all valid/data outputs 0 immediately, without a clock edge; in_ready_o=1.
6. With PIPE_TRACE_EN defined: tags 0x001..0x004 track their payloads through a stall; a bubble inserted by that stall carries tag 0.

Source files
------------

// File: rtl/pipe_wall_pkg.sv
// Shared constants, stage control encoding and sizing helper for the pipeline register chain.
package pipe_wall_pkg;

   localparam int unsigned PIPE_MAX_DEPTH = 8;
   localparam int unsigned PIPE_NOP       = 0;

   typedef enum logic [1:0] {
      CTL_LOAD,
      CTL_HOLD,
      CTL_BUBBLE,
      CTL_FLUSH
   } stage_ctl_e;

   // Bits needed to count 0..depth valid stages.
   function automatic int unsigned clog2_depth(input int unsigned depth);
      int unsigned bits;
      bits = 0;
      while ((32'd1 << bits) < (depth + 32'd1)) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/pipe_wall_stage.sv
// One pipeline wall register: valid + payload (+ trace tag when PIPE_TRACE_EN is defined),
// updated according to the control decision made by the parent chain.
module pipe_wall_stage
   import pipe_wall_pkg::*;
#(
   parameter int unsigned WIDTH = 32
`ifdef PIPE_TRACE_EN
   , parameter int unsigned TAG_W = 10
`endif
) (
   input  logic             clock,
   input  logic             reset_n,
   input  stage_ctl_e       ctl_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
`ifdef PIPE_TRACE_EN
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o,
`endif
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Bubble and flush both load the NOP encoding.
   always_comb begin : p_next
      valid_d = valid_q;
      data_d  = data_q;
      case (ctl_i)
         CTL_LOAD: begin
            valid_d = valid_i;
            data_d  = data_i;
         end
         CTL_HOLD: begin
            valid_d = valid_q;
            data_d  = data_q;
         end
         CTL_BUBBLE, CTL_FLUSH: begin
            valid_d = 1'b0;
            data_d  = WIDTH'(PIPE_NOP);
         end
         default: begin
            valid_d = valid_q;
            data_d  = data_q;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin : p_reg
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef PIPE_TRACE_EN
   logic [TAG_W-1:0] tag_q, tag_d;

   always_comb begin : p_tag_next
      tag_d = tag_q;
      case (ctl_i)
         CTL_LOAD:              tag_d = tag_i;
         CTL_HOLD:              tag_d = tag_q;
         CTL_BUBBLE, CTL_FLUSH: tag_d = TAG_W'(PIPE_NOP);
         default:               tag_d = tag_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin : p_tag_reg
      if (!reset_n) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign tag_o = tag_q;
`endif

endmodule

// File: rtl/pipe_wall_chain.sv
// Parametrised pipeline register chain with per-stage stall/back-pressure, flush and bubble
// insertion. Optional trace tags per stage when PIPE_TRACE_EN is defined.
module pipe_wall_chain
   import pipe_wall_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
`ifdef PIPE_TRACE_EN
   , parameter int unsigned TAG_W = 10
`endif
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in_valid_i,
   input  logic [WIDTH-1:0]              in_data_i,
`ifdef PIPE_TRACE_EN
   input  logic [TAG_W-1:0]              in_tag_i,
   output logic [DEPTH*TAG_W-1:0]        stage_tag_o,
`endif
   output logic                          in_ready_o,
   input  logic [DEPTH-1:0]              stall_i,
   input  logic [DEPTH-1:0]              flush_i,
   output logic [DEPTH-1:0]              stage_valid_o,
   output logic [DEPTH*WIDTH-1:0]        stage_data_o,
   output logic                          out_valid_o,
   output logic [WIDTH-1:0]              out_data_o,
   output logic [clog2_depth(DEPTH)-1:0] occupancy_o
);

   localparam int unsigned OCC_W = clog2_depth(DEPTH);

   logic [DEPTH-1:0] hold;

   // A stall freezes its own stage and everything upstream of it.
   always_comb begin : p_hold
      logic acc;
      acc  = 1'b0;
      hold = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         acc     = acc | stall_i[k];
         hold[k] = acc;
      end
   end

   assign in_ready_o = ~hold[0];

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
      stage_ctl_e       ctl;
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
`ifdef PIPE_TRACE_EN
      logic [TAG_W-1:0] src_tag;
`endif

      if (g == 0) begin : g_head
         assign src_valid = in_valid_i;
         assign src_data  = in_data_i;
`ifdef PIPE_TRACE_EN
         assign src_tag   = in_tag_i;
`endif
         always_comb begin : p_ctl
            ctl = CTL_LOAD;
            if (flush_i[g]) begin
               ctl = CTL_FLUSH;
            end else if (hold[g]) begin
               ctl = CTL_HOLD;
            end
         end
      end else begin : g_body
         // Reads the upstream register directly, so a flushed upstream still hands over its old contents.
         assign src_valid = stage_valid_o[g-1];
         assign src_data  = stage_data_o[(g-1)*WIDTH +: WIDTH];
`ifdef PIPE_TRACE_EN
         assign src_tag   = stage_tag_o[(g-1)*TAG_W +: TAG_W];
`endif
         always_comb begin : p_ctl
            ctl = CTL_LOAD;
            if (flush_i[g]) begin
               ctl = CTL_FLUSH;
            end else if (hold[g]) begin
               ctl = CTL_HOLD;
            end else if (hold[g-1]) begin
               ctl = CTL_BUBBLE;
            end
         end
      end

      pipe_wall_stage #(
         .WIDTH (WIDTH)
`ifdef PIPE_TRACE_EN
         , .TAG_W (TAG_W)
`endif
      ) u_stage (
         .clock   (clock),
         .reset_n (reset_n),
         .ctl_i   (ctl),
         .valid_i (src_valid),
         .data_i  (src_data),
`ifdef PIPE_TRACE_EN
         .tag_i   (src_tag),
         .tag_o   (stage_tag_o[g*TAG_W +: TAG_W]),
`endif
         .valid_o (stage_valid_o[g]),
         .data_o  (stage_data_o[g*WIDTH +: WIDTH])
      );
   end

   assign out_valid_o = stage_valid_o[DEPTH-1];
   assign out_data_o  = stage_data_o[(DEPTH-1)*WIDTH +: WIDTH];

   always_comb begin : p_occ
      occupancy_o = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         occupancy_o = occupancy_o + OCC_W'(stage_valid_o[k]);
      end
   end

endmodule

// File: tb/tb_pipe_wall_chain.sv
// Randomised and directed bench for pipe_wall_chain against a behavioural stage-array model.
module tb_pipe_wall_chain;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 4;
   localparam int unsigned OW = 3;
`ifdef PIPE_TRACE_EN
   localparam int unsigned TW = 10;
`endif

   logic              clock = 1'b0;
   logic              reset_n;
   logic              in_valid_i;
   logic [W-1:0]      in_data_i;
   logic              in_ready_o;
   logic [D-1:0]      stall_i;
   logic [D-1:0]      flush_i;
   logic [D-1:0]      stage_valid_o;
   logic [D*W-1:0]    stage_data_o;
   logic              out_valid_o;
   logic [W-1:0]      out_data_o;
   logic [OW-1:0]     occupancy_o;
`ifdef PIPE_TRACE_EN
   logic [TW-1:0]     in_tag_i;
   logic [D*TW-1:0]   stage_tag_o;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   pipe_wall_chain #(.WIDTH(W), .DEPTH(D)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid_i    (in_valid_i),
      .in_data_i     (in_data_i),
`ifdef PIPE_TRACE_EN
      .in_tag_i      (in_tag_i),
      .stage_tag_o   (stage_tag_o),
`endif
      .in_ready_o    (in_ready_o),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .stage_valid_o (stage_valid_o),
      .stage_data_o  (stage_data_o),
      .out_valid_o   (out_valid_o),
      .out_data_o    (out_data_o),
      .occupancy_o   (occupancy_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Behavioural model: stages at or below the highest stalled index freeze,
   // the stage right after it takes a bubble, the rest shift; flush overrides everything.
   logic         m_valid [D];
   logic [W-1:0] m_data  [D];
`ifdef PIPE_TRACE_EN
   logic [TW-1:0] m_tag  [D];
`endif

   always @(posedge clock or negedge reset_n) begin
      logic         nv [D];
      logic [W-1:0] nd [D];
`ifdef PIPE_TRACE_EN
      logic [TW-1:0] nt [D];
`endif
      int top;
      if (!reset_n) begin
         for (int k = 0; k < D; k++) begin
            m_valid[k] <= 1'b0;
            m_data[k]  <= '0;
`ifdef PIPE_TRACE_EN
            m_tag[k]   <= '0;
`endif
         end
      end else begin
         top = -1;
         for (int k = 0; k < D; k++) if (stall_i[k]) top = k;
         for (int k = 0; k < D; k++) begin
            nv[k] = m_valid[k];
            nd[k] = m_data[k];
`ifdef PIPE_TRACE_EN
            nt[k] = m_tag[k];
`endif
            if (flush_i[k] || (k == top + 1 && k > 0 && !(k <= top))) begin
               nv[k] = 1'b0;
               nd[k] = '0;
`ifdef PIPE_TRACE_EN
               nt[k] = '0;
`endif
            end else if (k <= top) begin
               nv[k] = m_valid[k];
            end else if (k == 0) begin
               nv[k] = in_valid_i;
               nd[k] = in_data_i;
`ifdef PIPE_TRACE_EN
               nt[k] = in_tag_i;
`endif
            end else begin
               nv[k] = m_valid[k-1];
               nd[k] = m_data[k-1];
`ifdef PIPE_TRACE_EN
               nt[k] = m_tag[k-1];
`endif
            end
         end
         for (int k = 0; k < D; k++) begin
            m_valid[k] <= nv[k];
            m_data[k]  <= nd[k];
`ifdef PIPE_TRACE_EN
            m_tag[k]   <= nt[k];
`endif
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      logic [D-1:0]   ev;
      logic [D*W-1:0] ed;
      int             occ;
`ifdef PIPE_TRACE_EN
      logic [D*TW-1:0] et;
`endif
      if (chk_en) begin
         occ = 0;
         for (int k = 0; k < D; k++) begin
            ev[k]         = m_valid[k];
            ed[k*W +: W]  = m_data[k];
            occ           = occ + int'(m_valid[k]);
`ifdef PIPE_TRACE_EN
            et[k*TW +: TW] = m_tag[k];
`endif
         end
         check("cyc_stage_valid", 128'(stage_valid_o), 128'(ev));
         check("cyc_stage_data",  128'(stage_data_o),  128'(ed));
         check("cyc_out_valid",   128'(out_valid_o),   128'(m_valid[D-1]));
         check("cyc_out_data",    128'(out_data_o),    128'(m_data[D-1]));
         check("cyc_occupancy",   128'(occupancy_o),   128'(occ));
         check("cyc_in_ready",    128'(in_ready_o),    128'(stall_i == '0));
`ifdef PIPE_TRACE_EN
         check("cyc_stage_tag",   128'(stage_tag_o),   128'(et));
`endif
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] d, input logic [D-1:0] st, input logic [D-1:0] fl);
      in_valid_i = v;
      in_data_i  = d;
      stall_i    = st;
      flush_i    = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic async_reset();
      in_valid_i = 1'b0;
      stall_i    = '0;
      flush_i    = '0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_stage_valid", 128'(stage_valid_o), 128'(0));
      check("rst_stage_data",  128'(stage_data_o),  128'(0));
      check("rst_out_valid",   128'(out_valid_o),   128'(0));
      check("rst_occupancy",   128'(occupancy_o),   128'(0));
      check("rst_in_ready",    128'(in_ready_o),    128'(1));
      @(negedge clock);
      #1 reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n    = 1'b1;
      in_valid_i = 1'b0;
      in_data_i  = '0;
      stall_i    = '0;
      flush_i    = '0;
`ifdef PIPE_TRACE_EN
      in_tag_i   = '0;
`endif
      #1 reset_n = 1'b0;
      #1;
      check("init_stage_valid", 128'(stage_valid_o), 128'(0));
      check("init_out_data",    128'(out_data_o),    128'(0));
      check("init_in_ready",    128'(in_ready_o),    128'(1));
      @(negedge clock);
      #1 reset_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // Streaming
      drive(1'b1, 32'h11, '0, '0); tick();
      drive(1'b1, 32'h22, '0, '0); tick();
      drive(1'b1, 32'h33, '0, '0); tick();
      drive(1'b1, 32'h44, '0, '0); tick();
      check("stream_first_out",  128'(out_data_o),  128'(32'h11));
      check("stream_out_valid",  128'(out_valid_o), 128'(1));
      check("stream_occ_full",   128'(occupancy_o), 128'(4));
      check("model_first_out",   128'(m_data[D-1]), 128'(32'h11));
      drive(1'b1, 32'h55, '0, '0); tick();
      check("stream_second_out", 128'(out_data_o),  128'(32'h22));

      // Mid-stall on stage 2
      drive(1'b1, 32'h66, 4'b0100, '0);
      check("stall_in_ready", 128'(in_ready_o), 128'(0));
      tick();
      check("stall_bubble_valid", 128'(out_valid_o), 128'(0));
      check("stall_bubble_data",  128'(out_data_o),  128'(0));
      check("stall_hold_data", 128'(stage_data_o[3*W-1:0]), 128'({32'h33, 32'h44, 32'h55}));
      tick();
      check("stall2_bubble_valid", 128'(out_valid_o), 128'(0));
      drive(1'b1, 32'h66, '0, '0);
      check("unstall_in_ready", 128'(in_ready_o), 128'(1));
      tick();
      check("unstall_out", 128'(out_data_o), 128'(32'h33));
      check("unstall_stages", 128'(stage_data_o), {32'h33, 32'h44, 32'h55, 32'h66});

      // Flush beats stall on the same stage; upstream still holds
      drive(1'b1, 32'h77, 4'b0010, 4'b0010); tick();
      check("flushpri_valid", 128'(stage_valid_o), 128'(4'b1001));
      check("flushpri_data",  128'(stage_data_o),  {32'h44, 32'h0, 32'h0, 32'h66});

      // Branch flush of stages 0 and 1
      drive(1'b1, 32'hA3, '0, '0); tick();
      drive(1'b1, 32'hA2, '0, '0); tick();
      drive(1'b1, 32'hA1, '0, '0); tick();
      drive(1'b1, 32'hA0, '0, '0); tick();
      check("branch_pre_occ", 128'(occupancy_o), 128'(4));
      drive(1'b1, 32'hB0, '0, 4'b0011); tick();
      check("branch_valid", 128'(stage_valid_o), 128'(4'b1100));
      check("branch_data",  128'(stage_data_o),  {32'hA2, 32'hA1, 32'h0, 32'h0});
      check("branch_occ",   128'(occupancy_o),   128'(2));

      // Async reset with a full pipe
      drive(1'b1, 32'hC0, '0, '0); tick();
      drive(1'b1, 32'hC1, '0, '0); tick();
      drive(1'b1, 32'hC2, '0, '0); tick();
      drive(1'b1, 32'hC3, '0, '0); tick();
      check("full_before_reset", 128'(occupancy_o), 128'(4));
      async_reset();

`ifdef PIPE_TRACE_EN
      // Tags ride along with payload through a stall; the bubble carries tag 0
      in_tag_i = 10'h001; drive(1'b1, 32'h1, '0, '0); tick();
      in_tag_i = 10'h002; drive(1'b1, 32'h2, '0, '0); tick();
      in_tag_i = 10'h003; drive(1'b1, 32'h3, '0, '0); tick();
      in_tag_i = 10'h004; drive(1'b1, 32'h4, 4'b0010, '0); tick();
      check("tag_stall", 128'(stage_tag_o), 128'({10'h001, 10'h000, 10'h002, 10'h003}));
      drive(1'b1, 32'h4, '0, '0); tick();
      check("tag_resume", 128'(stage_tag_o), 128'({10'h000, 10'h002, 10'h003, 10'h004}));
`endif

      // Randomised traffic with stalls, flushes and one async reset
      for (int i = 0; i < 600; i++) begin
         logic [D-1:0] st;
         logic [D-1:0] fl;
         st = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
         fl = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
`ifdef PIPE_TRACE_EN
         in_tag_i = TW'($urandom);
`endif
         drive($urandom_range(0, 3) != 0, W'($urandom), st, fl);
         tick();
         if (i == 300) async_reset();
      end

      drive(1'b0, '0, '0, '0);
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
